spike_argmax_seq: RTL and testbench

SPIKE_ARGMAX_SEQ -- requirements
Module: spike_argmax_seq

---
 rtl/spike_argmax_seq.sv | 157 +++++++++++++++
 tb/tb_spike_argmax_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_argmax_seq.sv
// spike_argmax_seq: sequential argmax over a vector of output-neuron spike counters.
//
// A start request in IDLE snapshots all counts. SCAN then walks the snapshot one class
// per cycle, tracking the running max, runner-up and winning index. DONE presents the
// result until the consumer accepts it.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   start_i       classify request, taken only while start_ready_o is high
//   start_ready_o high in IDLE
//   counts_i      packed counts, class k at [k*COUNT_W +: COUNT_W]
//   valid_o       result available (DONE)
//   ready_i       consumer accepts result
//   digit_o       winning class index (lowest index on ties)
//   max_o         winning count
//   margin_o      winning count minus best count among the other classes
//   tie_o         another class equals the winning count
//   busy_o        high in SCAN and DONE
module spike_argmax_seq #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  output logic                           start_ready_o,
  input  logic [NUM_CLASSES*COUNT_W-1:0] counts_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [IDX_W-1:0]               digit_o,
  output logic [COUNT_W-1:0]             max_o,
  output logic [COUNT_W-1:0]             margin_o,
  output logic                           tie_o,
  output logic                           busy_o
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);

  state_e state_q, state_d;

  logic [COUNT_W-1:0] snap_q [NUM_CLASSES];

  logic [IDX_W-1:0]   scan_q, scan_d;
  logic [COUNT_W-1:0] max_q, max_d;
  logic [COUNT_W-1:0] second_q, second_d;
  logic [IDX_W-1:0]   arg_q, arg_d;

  // Result registers are separate from the running values so outputs stay frozen
  // through later scans until the next DONE.
  logic [IDX_W-1:0]   res_digit_q, res_digit_d;
  logic [COUNT_W-1:0] res_max_q, res_max_d;
  logic [COUNT_W-1:0] res_margin_q, res_margin_d;
  logic               res_tie_q, res_tie_d;

  logic [COUNT_W-1:0] cur;
  logic               accept;

  assign accept = (state_q == StIdle) && start_i;
  assign cur    = snap_q[scan_q];

  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    max_d        = max_q;
    second_d     = second_q;
    arg_d        = arg_q;
    res_digit_d  = res_digit_q;
    res_max_d    = res_max_q;
    res_margin_d = res_margin_q;
    res_tie_d    = res_tie_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StScan;
          scan_d   = '0;
          max_d    = '0;
          second_d = '0;
          arg_d    = '0;
        end
      end
      StScan: begin
        // Strict > keeps the lowest index on ties; an equal count still lifts the
        // runner-up so margin becomes zero.
        if (cur > max_q) begin
          second_d = max_q;
          max_d    = cur;
          arg_d    = scan_q;
        end else if (cur > second_q) begin
          second_d = cur;
        end
        if (scan_q == LastIdx) begin
          state_d      = StDone;
          res_digit_d  = arg_d;
          res_max_d    = max_d;
          res_margin_d = max_d - second_d;
          res_tie_d    = (max_d == second_d);
        end else begin
          scan_d = scan_q + IDX_W'(1);
        end
      end
      StDone: begin
        // start_i is deliberately not looked at here.
        if (ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      scan_q       <= '0;
      max_q        <= '0;
      second_q     <= '0;
      arg_q        <= '0;
      res_digit_q  <= '0;
      res_max_q    <= '0;
      res_margin_q <= '0;
      res_tie_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      max_q        <= max_d;
      second_q     <= second_d;
      arg_q        <= arg_d;
      res_digit_q  <= res_digit_d;
      res_max_q    <= res_max_d;
      res_margin_q <= res_margin_d;
      res_tie_q    <= res_tie_d;
    end
  end

  // Snapshot needs no reset: it is only read after an accept has loaded it.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        snap_q[k] <= counts_i[k*COUNT_W +: COUNT_W];
      end
    end
  end

  assign start_ready_o = (state_q == StIdle);
  assign busy_o        = (state_q == StScan) || (state_q == StDone);
  assign valid_o       = (state_q == StDone);
  assign digit_o       = res_digit_q;
  assign max_o         = res_max_q;
  assign margin_o      = res_margin_q;
  assign tie_o         = res_tie_q;

endmodule

// File: tb/tb_spike_argmax_seq.sv
// Testbench for spike_argmax_seq: default-size instance checked every cycle against a
// cycle-count/argmax model, plus literal expectations and a 4-class / 4-bit instance.
module tb_spike_argmax_seq;

  localparam int N = 10;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, ready;
  logic [N*W-1:0] counts;
  logic         start_ready, valid, tie, busy;
  logic [3:0]   digit;
  logic [7:0]   max_v, margin;

  logic         start_b, ready_b;
  logic [15:0]  counts_b;
  logic         start_ready_b, valid_b, tie_b, busy_b;
  logic [1:0]   digit_b;
  logic [3:0]   max_b, margin_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spike_argmax_seq dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .start_ready_o(start_ready),
    .counts_i(counts), .valid_o(valid), .ready_i(ready), .digit_o(digit),
    .max_o(max_v), .margin_o(margin), .tie_o(tie), .busy_o(busy)
  );

  spike_argmax_seq #(.NUM_CLASSES(4), .COUNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .start_ready_o(start_ready_b),
    .counts_i(counts_b), .valid_o(valid_b), .ready_i(ready_b), .digit_o(digit_b),
    .max_o(max_b), .margin_o(margin_b), .tie_o(tie_b), .busy_o(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Argmax straight from the definition: lowest index holding the largest count, and
  // runner-up as the best count among every other class.
  function automatic void classify(input logic [N*W-1:0] v, output logic [3:0] d,
                                   output logic [7:0] mx, output logic [7:0] mg,
                                   output logic t);
    int best = -1;
    int bi = 0;
    int sec = 0;
    for (int k = 0; k < N; k++) begin
      if (int'(v[k*W +: W]) > best) begin
        best = int'(v[k*W +: W]);
        bi = k;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (k != bi && int'(v[k*W +: W]) > sec) sec = int'(v[k*W +: W]);
    end
    d  = 4'(bi);
    mx = 8'(best);
    mg = 8'(best - sec);
    t  = (best == sec);
  endfunction

  logic       m_busy = 1'b0, m_valid = 1'b0, m_tie = 1'b0, p_tie;
  logic [3:0] m_digit = '0, p_digit;
  logic [7:0] m_max = '0, m_margin = '0, p_max, p_margin;
  int         m_left = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 1'b0; m_valid = 1'b0; m_left = 0;
        m_digit = '0; m_max = '0; m_margin = '0; m_tie = 1'b0;
      end else if (m_valid) begin
        if (ready) m_valid = 1'b0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_valid = 1'b1;
          m_digit = p_digit; m_max = p_max; m_margin = p_margin; m_tie = p_tie;
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_left = N;
        classify(counts, p_digit, p_max, p_margin, p_tie);
      end
    end
  end

  // Every-cycle comparison, sampled just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("cyc_start_ready", 32'(start_ready), 32'(!m_busy && !m_valid));
      check("cyc_busy", 32'(busy), 32'(m_busy || m_valid));
      check("cyc_valid", 32'(valid), 32'(m_valid));
      check("cyc_digit", 32'(digit), 32'(m_digit));
      check("cyc_max", 32'(max_v), 32'(m_max));
      check("cyc_margin", 32'(margin), 32'(m_margin));
      check("cyc_tie", 32'(tie), 32'(m_tie));
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [N*W-1:0] pack10(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8,
                                            input int a9);
    return {8'(a9), 8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1),
            8'(a0)};
  endfunction

  function automatic logic [N*W-1:0] rand_counts();
    return {16'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  task automatic expect_res(input string tag, input int d, input int mx, input int mg,
                            input int t);
    check({tag, "_digit"}, 32'(digit), 32'(d));
    check({tag, "_max"}, 32'(max_v), 32'(mx));
    check({tag, "_margin"}, 32'(margin), 32'(mg));
    check({tag, "_tie"}, 32'(tie), 32'(t));
  endtask

  // Called on the negedge after the accept edge; returns edges until valid seen.
  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    while (!valid && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!valid) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: valid got 0, expected 1 within 100 cycles", tag);
    end
  endtask

  task automatic pulse_start(input logic [N*W-1:0] v);
    @(negedge clk);
    counts = v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [N*W-1:0] v, input int d,
                         input int mx, input int mg, input int t);
    int lat;
    pulse_start(v);
    wait_valid(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'(N));
    expect_res(tag, d, mx, mg, t);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; ready = 1'b1; counts = '0;
    start_b = 1'b0; ready_b = 1'b1; counts_b = '0;
    repeat (3) @(negedge clk);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    expect_res("rst", 0, 0, 0, 0);
    check("rst_b_start_ready", 32'(start_ready_b), 32'd1);
    check("rst_b_valid", 32'(valid_b), 32'd0);
    rst = 1'b0;

    run_one("mixed", pack10(3, 7, 2, 9, 1, 0, 4, 9, 5, 6), 3, 9, 0, 1);
    run_one("single", pack10(0, 0, 0, 0, 0, 0, 0, 0, 200, 0), 8, 200, 200, 0);
    run_one("zeros", '0, 0, 0, 0, 1);
    run_one("full", '1, 0, 255, 0, 1);
    run_one("last_wins", pack10(5, 5, 5, 5, 5, 5, 5, 5, 5, 6), 9, 6, 1, 0);

    // Hold in DONE while inputs churn.
    ready = 1'b0;
    pulse_start(pack10(1, 2, 3, 4, 5, 6, 7, 8, 9, 10));
    wait_valid("hold", lat);
    check("hold_latency", 32'(lat), 32'(N));
    for (int i = 0; i < 20; i++) begin
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_start_ready", 32'(start_ready), 32'd0);
      expect_res("hold", 9, 10, 1, 0);
      counts = rand_counts();
      start = (i % 2 == 0);
      @(negedge clk);
    end
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("release_valid", 32'(valid), 32'd0);
    check("release_start_ready", 32'(start_ready), 32'd1);
    expect_res("release", 9, 10, 1, 0);
    @(negedge clk);
    check("release_no_scan", 32'(busy), 32'd0);

    // Reset 4 cycles into a scan.
    pulse_start(pack10(0, 0, 0, 0, 0, 0, 0, 0, 200, 0));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      check("abort_valid", 32'(valid), 32'd0);
      check("abort_start_ready", 32'(start_ready), 32'd1);
      expect_res("abort", 0, 0, 0, 0);
      @(negedge clk);
    end
    run_one("after_abort", pack10(3, 7, 2, 9, 1, 0, 4, 9, 5, 6), 3, 9, 0, 1);

    // Reset while a result is waiting.
    ready = 1'b0;
    pulse_start(pack10(0, 0, 0, 0, 0, 0, 0, 0, 200, 0));
    wait_valid("done_rst", lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    check("done_rst_valid", 32'(valid), 32'd0);
    expect_res("done_rst", 0, 0, 0, 0);

    // Back-to-back with start held high; the model tracks every accept.
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      counts = rand_counts();
      @(negedge clk);
    end
    start = 1'b0;
    repeat (15) @(negedge clk);

    // Random counts with a stalling consumer.
    for (int r = 0; r < 6; r++) begin
      pulse_start(rand_counts());
      for (int i = 0; i < 30; i++) begin
        ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      ready = 1'b1;
      repeat (3) @(negedge clk);
    end

    // Small configuration: 4 classes of 4 bits.
    @(negedge clk);
    counts_b = {4'd1, 4'd15, 4'd14, 4'd15};
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    lat = 0;
    while (!valid_b && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("small_latency", 32'(lat), 32'd4);
    check("small_digit", 32'(digit_b), 32'd0);
    check("small_max", 32'(max_b), 32'd15);
    check("small_margin", 32'(margin_b), 32'd0);
    check("small_tie", 32'(tie_b), 32'd1);
    @(negedge clk);
    check("small_idle", 32'(start_ready_b), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got past 200000, expected to finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
